// File: rtl/shiftreg_sipo_param_if.sv
// Serial-in/parallel-out bus: strobes and serial data in, parallel/cascade/status out.
interface shiftreg_sipo_param_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             ser;
  logic             shift_en;
  logic             latch_en;
  logic             srclr_n;
  logic             oe_n;
  logic [WIDTH-1:0] q;
  logic             q_ser;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_full;
  logic             latch_partial;

  modport master (
    output ser, shift_en, latch_en, srclr_n, oe_n,
    input  q, q_ser, bit_cnt, frame_full, latch_partial
  );

  modport slave (
    input  ser, shift_en, latch_en, srclr_n, oe_n,
    output q, q_ser, bit_cnt, frame_full, latch_partial
  );
endinterface

// File: rtl/shiftreg_sipo_param.sv
// Single-clock 595-style SIPO shift register with storage latch, bit counter,
// frame-full flag and sticky partial-latch flag. Cascade via q_ser -> ser.
module shiftreg_sipo_param #(
  parameter int WIDTH     = 8,   // >= 2
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  shiftreg_sipo_param_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [WIDTH-1:0] store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             partial_q, partial_d;
  logic             shift_ok;

  // Shift direction decides which end the serial bit enters and which end feeds the cascade.
  if (MSB_FIRST) begin : g_msb
    assign sr_shift  = {sr_q[WIDTH-2:0], bus.ser};
    assign bus.q_ser = sr_q[WIDTH-1];
  end else begin : g_lsb
    assign sr_shift  = {bus.ser, sr_q[WIDTH-1:1]};
    assign bus.q_ser = sr_q[0];
  end

  // Clear wins over shift; a shift is only "accepted" when not cleared.
  assign shift_ok = bus.shift_en & bus.srclr_n;
  assign cnt_inc  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state: latch always samples pre-edge SR/count, so same-edge shift+latch lags by one bit.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    store_d   = store_q;
    partial_d = partial_q;
    if (!bus.srclr_n) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (bus.shift_en) begin
      sr_d  = sr_shift;
      cnt_d = cnt_inc;
    end
    if (bus.latch_en) begin
      store_d   = sr_q;
      partial_d = (cnt_q != CNT_FULL);
      // Counter restarts the frame; a same-edge accepted shift is the first bit of the new one.
      cnt_d     = shift_ok ? CNT_W'(1) : '0;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q      <= '0;
      store_q   <= '0;
      cnt_q     <= '0;
      partial_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
    end
  end

  // Output enable gates only the parallel bus; storage and cascade are unaffected.
  assign bus.q             = bus.oe_n ? '0 : store_q;
  assign bus.bit_cnt       = cnt_q;
  assign bus.frame_full    = (cnt_q == CNT_FULL);
  assign bus.latch_partial = partial_q;
endmodule

// File: tb/tb_shiftreg_sipo_param.sv
// Directed bench for shiftreg_sipo_param with queue-based scoreboard and a separate monitor.
module tb_shiftreg_sipo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shiftreg_sipo_param_if #(.WIDTH(8)) i0 ();
  shiftreg_sipo_param_if #(.WIDTH(8)) iu ();
  shiftreg_sipo_param_if #(.WIDTH(8)) id ();
  shiftreg_sipo_param_if #(.WIDTH(4)) i4 ();

  shiftreg_sipo_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u0   (.clk_i(clk), .rst_i(rst), .bus(i0));
  shiftreg_sipo_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_up (.clk_i(clk), .rst_i(rst), .bus(iu));
  shiftreg_sipo_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dn (.clk_i(clk), .rst_i(rst), .bus(id));
  shiftreg_sipo_param #(.WIDTH(4), .MSB_FIRST(1'b0)) u4   (.clk_i(clk), .rst_i(rst), .bus(i4));

  // Downstream stage shares the upstream strobes and takes its serial input from the cascade.
  assign id.ser      = iu.q_ser;
  assign id.shift_en = iu.shift_en;
  assign id.latch_en = iu.latch_en;
  assign id.srclr_n  = iu.srclr_n;
  assign id.oe_n     = iu.oe_n;

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] q;
    logic       q_ser;
    logic [3:0] cnt;
    logic       ff;
    logic       lp;
  } exp_t;

  exp_t sb[$];
  event kick;
  int   n_checks = 0;
  int   n_errors = 0;

  // Monitor: compares every queued expectation against the selected DUT.
  initial begin
    exp_t e;
    logic [7:0] aq;
    logic       aqs, aff, alp;
    logic [3:0] acnt;
    forever begin
      @(negedge clk or kick);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          0:       begin aq = i0.q; aqs = i0.q_ser; acnt = i0.bit_cnt; aff = i0.frame_full; alp = i0.latch_partial; end
          1:       begin aq = iu.q; aqs = iu.q_ser; acnt = iu.bit_cnt; aff = iu.frame_full; alp = iu.latch_partial; end
          2:       begin aq = id.q; aqs = id.q_ser; acnt = id.bit_cnt; aff = id.frame_full; alp = id.latch_partial; end
          default: begin aq = 8'(i4.q); aqs = i4.q_ser; acnt = 4'(i4.bit_cnt); aff = i4.frame_full; alp = i4.latch_partial; end
        endcase
        n_checks++;
        if (aq !== e.q || aqs !== e.q_ser || acnt !== e.cnt || aff !== e.ff || alp !== e.lp) begin
          n_errors++;
          $display("FAIL %s: got q=%h q_ser=%b cnt=%0d ff=%b lp=%b, want q=%h q_ser=%b cnt=%0d ff=%b lp=%b",
                   e.name, aq, aqs, acnt, aff, alp, e.q, e.q_ser, e.cnt, e.ff, e.lp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic exp_t mk(string n, int d, logic [7:0] q, logic qs, logic [3:0] c, logic ff, logic lp);
    exp_t e;
    e.name = n; e.dut = d; e.q = q; e.q_ser = qs; e.cnt = c; e.ff = ff; e.lp = lp;
    return e;
  endfunction

  // Checked at the next falling edge.
  task automatic chk(string n, int d, logic [7:0] q, logic qs, logic [3:0] c, logic ff, logic lp);
    sb.push_back(mk(n, d, q, qs, c, ff, lp));
    @(negedge clk); #1;
  endtask

  // Checked immediately, with no clock edge in between.
  task automatic chk_now(string n, int d, logic [7:0] q, logic qs, logic [3:0] c, logic ff, logic lp);
    sb.push_back(mk(n, d, q, qs, c, ff, lp));
    ->kick;
    #1;
  endtask

  task automatic shift0(logic [7:0] pat, int n);
    for (int i = n - 1; i >= 0; i--) begin
      i0.ser = pat[i]; i0.shift_en = 1'b1; cyc();
    end
    i0.shift_en = 1'b0; i0.ser = 1'b0;
  endtask

  task automatic latch0();
    i0.latch_en = 1'b1; cyc(); i0.latch_en = 1'b0;
  endtask

  initial begin
    logic [15:0] casc;
    logic [3:0]  b4;
    casc = 16'hA55A;
    b4   = 4'b1000;
    i0.ser = 0; i0.shift_en = 0; i0.latch_en = 0; i0.srclr_n = 1; i0.oe_n = 0;
    iu.ser = 0; iu.shift_en = 0; iu.latch_en = 0; iu.srclr_n = 1; iu.oe_n = 0;
    i4.ser = 0; i4.shift_en = 0; i4.latch_en = 0; i4.srclr_n = 1; i4.oe_n = 0;

    cyc(); cyc();
    chk("reset", 0, 8'h00, 0, 0, 0, 0);
    rst = 1'b0;

    // Full frame 1,0,1,1,0,0,1,0 then latch.
    shift0(8'hB2, 8);
    chk("frame_full", 0, 8'h00, 1, 8, 1, 0);
    latch0();
    chk("latch_full", 0, 8'hB2, 1, 0, 0, 0);

    // Output enable only masks Q.
    i0.oe_n = 1'b1; #1;
    chk("oe_off", 0, 8'h00, 1, 0, 0, 0);
    i0.oe_n = 1'b0; #1;
    chk("oe_on", 0, 8'hB2, 1, 0, 0, 0);

    // Same-edge shift+latch: STORE gets pre-shift SR, count restarts at 1, pre-edge count 0 -> partial.
    i0.ser = 1; i0.shift_en = 1; i0.latch_en = 1; cyc();
    i0.ser = 0; i0.shift_en = 0; i0.latch_en = 0;
    chk("shift_latch", 0, 8'hB2, 0, 1, 0, 1);

    // Fill with ones; count saturates at 8.
    shift0(8'hFF, 8);
    chk("saturate", 0, 8'hB2, 1, 8, 1, 1);

    // Clear overrides shift, STORE untouched.
    i0.srclr_n = 0; i0.shift_en = 1; i0.ser = 1; cyc();
    i0.srclr_n = 1; i0.shift_en = 0; i0.ser = 0;
    chk("clear", 0, 8'hB2, 0, 0, 0, 1);
    latch0();
    chk("latch_clr", 0, 8'h00, 0, 0, 0, 1);

    // Partial frame of five ones.
    shift0(8'h1F, 5);
    chk("five", 0, 8'h00, 0, 5, 0, 1);
    latch0();
    chk("latch_part", 0, 8'h1F, 0, 0, 0, 1);
    shift0(8'h3C, 8);
    latch0();
    chk("latch_full2", 0, 8'h3C, 0, 0, 0, 0);
    shift0(8'h07, 3);
    chk("three", 0, 8'h3C, 1, 3, 0, 0);

    // Asynchronous reset mid-cycle.
    cyc();
    rst = 1'b1; #1;
    chk_now("async_rst", 0, 8'h00, 0, 0, 0, 0);
    cyc(); cyc();
    rst = 1'b0;

    // Two-stage cascade, 16 bits MSB first.
    for (int i = 15; i >= 0; i--) begin
      iu.ser = casc[i]; iu.shift_en = 1'b1; cyc();
    end
    iu.shift_en = 0; iu.ser = 0;
    iu.latch_en = 1; cyc(); iu.latch_en = 0;
    chk("casc_up", 1, 8'h5A, 0, 0, 0, 0);
    chk("casc_dn", 2, 8'hA5, 1, 0, 0, 0);

    // WIDTH=4, LSB-directed shifting.
    for (int i = 3; i >= 0; i--) begin
      i4.ser = b4[i]; i4.shift_en = 1'b1; cyc();
    end
    i4.shift_en = 0; i4.ser = 0;
    chk("w4_full", 3, 8'h00, 1, 4, 1, 0);
    i4.latch_en = 1; cyc(); i4.latch_en = 0;
    chk("w4_latch", 3, 8'h01, 1, 0, 0, 0);

    cyc(); cyc();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #50000;
    n_errors++;
    $display("FAIL timeout: bench still running at %0t, want finished", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
